encoder_frame_sequencer: RTL and testbench

Per-PPDU controller in front of the 802.11a convolutional encoder. It takes one frame descriptor (rate, length) and the frame's payload word stream. It emits the encoder's input stream in order: the SIGNAL word at 6 Mb/s, then the DATA-field payload words, zero-masked past the last payload bit, then zero pad words up to the OFDM symbol boundary. It drives the per-word rate on `tuser` and `tlast` on the final word, so the encoder's history is flushed to zero at field and frame boundaries.

---
 rtl/encoder_frame_sequencer_pkg.sv | 57 +++++
 rtl/encoder_frame_sequencer_signal_field_builder.sv | 30 +++
 rtl/encoder_frame_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_encoder_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// encoder_frame_sequencer_pkg : shared ieee80211 defs (rates, N_DBPS, SIGNAL layout)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package encoder_frame_sequencer_pkg;

  // Rate codes as {R1,R2,R3,R4}, R1 in the MSB of the 4-bit code
  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  localparam int TAIL_BITS    = 6;
  localparam int SERVICE_BITS = 16;

  localparam int SIG_RATE_LSB   = 0;
  localparam int SIG_RESERVED   = 4;
  localparam int SIG_LENGTH_LSB = 5;
  localparam int SIG_PARITY     = 17;
  localparam int SIG_BODY_BITS  = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_SIGNAL  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PAD     = 3'd4
  } seq_state_t;

  // Zero marks an illegal rate code
  function automatic logic [7:0] rate_ndbps(input logic [3:0] rate);
    case (rate)
      RATE_6M:  rate_ndbps = 8'd24;
      RATE_9M:  rate_ndbps = 8'd36;
      RATE_12M: rate_ndbps = 8'd48;
      RATE_18M: rate_ndbps = 8'd72;
      RATE_24M: rate_ndbps = 8'd96;
      RATE_36M: rate_ndbps = 8'd144;
      RATE_48M: rate_ndbps = 8'd192;
      RATE_54M: rate_ndbps = 8'd216;
      default:  rate_ndbps = 8'd0;
    endcase
  endfunction

  function automatic logic rate_is_legal(input logic [3:0] rate);
    rate_is_legal = (rate_ndbps(rate) != 8'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_frame_sequencer_signal_field_builder.sv
// ---------------------------------------------------------------------------
// signal_field_builder : 24-bit SIGNAL word from rate code and length
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module signal_field_builder
  import encoder_frame_sequencer_pkg::*;
(
  input  logic [3:0]  rate,
  input  logic [11:0] length,
  output logic [23:0] signal_word
);

  logic [SIG_BODY_BITS-1:0] body;

  always_comb begin
    body = '0;
    // R1 is the first bit on air, so the code is bit-reversed into [3:0]
    body[SIG_RATE_LSB +: 4]    = {rate[0], rate[1], rate[2], rate[3]};
    body[SIG_RESERVED]         = 1'b0;
    body[SIG_LENGTH_LSB +: 12] = length;
    signal_word                = '0;
    signal_word[SIG_BODY_BITS-1:0] = body;
    signal_word[SIG_PARITY]    = ^body;
  end

endmodule

`default_nettype wire

// File: rtl/encoder_frame_sequencer.sv
// ---------------------------------------------------------------------------
// encoder_frame_sequencer : SIGNAL / payload / pad word sequencer ahead of the encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module encoder_frame_sequencer
  import encoder_frame_sequencer_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [3:0]       cfg_rate,
  input  logic [11:0]      cfg_length,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [3:0]       m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             err
);

  localparam logic [15:0] WORD_STEP = 16'(WIDTH);
  localparam logic [15:0] TAIL_PAD  = 16'(TAIL_BITS);

  seq_state_t       state_q,   state_d;
  logic [3:0]       rate_q,    rate_d;
  logic [11:0]      length_q,  length_d;
  logic [7:0]       ndbps_q,   ndbps_d;
  logic [15:0]      nbits_q,   nbits_d;
  logic [15:0]      acc_q,     acc_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tdata_q,   tdata_d;
  logic [3:0]       tuser_q,   tuser_d;
  logic             tvalid_q,  tvalid_d;
  logic             tlast_q,   tlast_d;
  logic             err_q,     err_d;

  logic             out_load;
  logic [WIDTH-1:0] keep_mask;
  logic [23:0]      signal_word;
  logic [15:0]      acc_sum;
  logic [15:0]      bit_cnt_next;

  signal_field_builder u_signal (
    .rate        (rate_q),
    .length      (length_q),
    .signal_word (signal_word)
  );

  assign out_load      = ~tvalid_q | m_axis_tready;
  // A new descriptor waits until the previous frame's last word has left
  assign cfg_ready     = ~areset & (state_q == ST_IDLE) & ~tvalid_q;
  assign s_axis_tready = (state_q == ST_PAYLOAD) & out_load;
  assign busy          = (state_q != ST_IDLE);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign err           = err_q;

  assign acc_sum      = acc_q + {8'd0, ndbps_q};
  assign bit_cnt_next = bit_cnt_q + WORD_STEP;

  always_comb begin
    keep_mask = '0;
    for (int j = 0; j < WIDTH; j++) begin
      keep_mask[j] = (bit_cnt_q + 16'(j)) < nbits_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    length_d  = length_q;
    ndbps_d   = ndbps_q;
    nbits_d   = nbits_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    err_d     = 1'b0;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          if (rate_is_legal(cfg_rate)) begin
            rate_d    = cfg_rate;
            length_d  = cfg_length;
            ndbps_d   = rate_ndbps(cfg_rate);
            nbits_d   = 16'(SERVICE_BITS) + {1'b0, cfg_length, 3'b000};
            acc_d     = '0;
            bit_cnt_d = '0;
            state_d   = ST_CALC;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // acc ends as N_SYM*N_DBPS, the data-field size in bits
      ST_CALC: begin
        acc_d = acc_sum;
        if (acc_sum >= nbits_q + TAIL_PAD) begin
          state_d = ST_SIGNAL;
        end
      end

      ST_SIGNAL: begin
        if (out_load) begin
          tdata_d  = signal_word;
          tuser_d  = RATE_6M;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (s_axis_tvalid && s_axis_tready) begin
          tdata_d   = s_axis_tdata & keep_mask;
          tuser_d   = rate_q;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          bit_cnt_d = bit_cnt_next;
          if (s_axis_tlast != (bit_cnt_next >= nbits_q)) begin
            err_d = 1'b1;
          end
          if (bit_cnt_next >= nbits_q) begin
            if (bit_cnt_next >= acc_q) begin
              tlast_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        if (out_load) begin
          tdata_d   = '0;
          tuser_d   = rate_q;
          tvalid_d  = 1'b1;
          bit_cnt_d = bit_cnt_next;
          tlast_d   = (bit_cnt_next >= acc_q);
          if (bit_cnt_next >= acc_q) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      rate_q    <= '0;
      length_q  <= '0;
      ndbps_q   <= '0;
      nbits_q   <= '0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      length_q  <= length_d;
      ndbps_q   <= ndbps_d;
      nbits_q   <= nbits_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      err_q     <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_encoder_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_encoder_frame_sequencer : randomized frames against a word-list reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_encoder_frame_sequencer;

  localparam int WIDTH = 24;
  localparam logic [3:0] R6  = 4'b1101;
  localparam logic [3:0] R9  = 4'b1111;
  localparam logic [3:0] R12 = 4'b0101;
  localparam logic [3:0] R18 = 4'b0111;
  localparam logic [3:0] R24 = 4'b1001;
  localparam logic [3:0] R36 = 4'b1011;
  localparam logic [3:0] R48 = 4'b0001;
  localparam logic [3:0] R54 = 4'b0011;

  logic             aclk = 1'b0;
  logic             areset;
  logic [3:0]       cfg_rate;
  logic [11:0]      cfg_length;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [WIDTH-1:0] m_axis_tdata;
  logic [3:0]       m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             busy;
  logic             err;

  always #5 aclk = ~aclk;

  encoder_frame_sequencer #(.WIDTH(WIDTH)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_rate      (cfg_rate),
    .cfg_length    (cfg_length),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .err           (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected output words as {3'b0, tlast, tuser, tdata}
  logic [31:0] exp_q[$];
  logic [23:0] pay_q[$];
  int  pay_idx, cyc, hs_cfg_cyc, first_valid_cyc, err_cnt, out_cnt;
  int  exp_words, exp_nsym;
  bit  exp_legal, drop_tlast, stall_en, gaps_en, cfg_pending, s_acc;
  logic [23:0] first_word;

  function automatic int model_ndbps(input logic [3:0] r);
    case (r)
      R6:  return 24;
      R9:  return 36;
      R12: return 48;
      R18: return 72;
      R24: return 96;
      R36: return 144;
      R48: return 192;
      R54: return 216;
      default: return 0;
    endcase
  endfunction

  // Sample DUT at negedge, drive, then note handshakes that the next posedge will take
  task automatic step();
    @(negedge aclk);
    cyc++;
    if (!areset) begin
      if (err) err_cnt++;
      if (m_axis_tvalid) begin
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          first_word      = m_axis_tdata;
        end
        if (exp_q.size() == 0)
          check("unexpected_tvalid", 32'(m_axis_tvalid), 32'd0);
        else
          check("out_word", {3'b0, m_axis_tlast, m_axis_tuser, m_axis_tdata}, exp_q[0]);
      end
    end
    m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    cfg_valid     = cfg_pending;
    if (s_acc) begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_acc         = 1'b0;
    end
    if (!s_axis_tvalid && pay_idx < pay_q.size() && (!gaps_en || $urandom_range(0, 3) != 0)) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pay_q[pay_idx];
      s_axis_tlast  = (pay_idx == pay_q.size() - 1) && !drop_tlast;
    end
    #1;
    if (cfg_valid && cfg_ready) begin
      cfg_pending = 1'b0;
      hs_cfg_cyc  = cyc;
    end
    if (!areset && m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      out_cnt++;
    end
    if (s_axis_tvalid && s_axis_tready) begin
      pay_idx++;
      s_acc = 1'b1;
    end
  endtask

  task automatic prepare_frame(input logic [3:0] r, input int len, input bit ones,
                               input bit no_tlast, input bit stall, input bit gaps);
    int ndbps, nbits, total, npay, ndata, sig;
    logic [3:0]  rev;
    logic [23:0] w;
    logic [31:0] rnd;
    exp_q.delete();
    pay_q.delete();
    pay_idx = 0; s_acc = 1'b0;
    err_cnt = 0; out_cnt = 0; first_valid_cyc = -1; hs_cfg_cyc = -1;
    drop_tlast = no_tlast; stall_en = stall; gaps_en = gaps;
    ndbps     = model_ndbps(r);
    exp_legal = (ndbps != 0);
    exp_words = 0;
    exp_nsym  = 0;
    if (exp_legal) begin
      nbits    = 16 + 8 * len;
      exp_nsym = (nbits + 6 + ndbps - 1) / ndbps;
      total    = exp_nsym * ndbps;
      npay     = (nbits + 23) / 24;
      ndata    = (total + 23) / 24;
      exp_words = ndata + 1;
      rev = {r[0], r[1], r[2], r[3]};
      sig = int'(rev) + len * 32;
      sig = sig + (($countones(sig) % 2) << 17);
      exp_q.push_back({3'b0, 1'b0, R6, 24'(sig)});
      for (int k = 0; k < ndata; k++) begin
        if (k < npay) begin
          rnd = $urandom();
          w   = ones ? 24'hFFFFFF : rnd[23:0];
          pay_q.push_back(w);
          for (int j = 0; j < 24; j++)
            if (k * 24 + j >= nbits) w[j] = 1'b0;
        end else begin
          w = 24'd0;
        end
        exp_q.push_back({3'b0, (k == ndata - 1), r, w});
      end
    end
    cfg_rate    = r;
    cfg_length  = 12'(len);
    cfg_pending = 1'b1;
  endtask

  task automatic run_frame(input logic [3:0] r, input int len, input bit ones,
                           input bit no_tlast, input bit stall, input bit gaps, input int exp_err);
    int budget;
    prepare_frame(r, len, ones, no_tlast, stall, gaps);
    budget = 0;
    do begin
      step();
      budget++;
    end while ((cfg_pending || exp_q.size() > 0 || pay_idx < pay_q.size()) && budget < 5000);
    check("frame_timeout", 32'(budget < 5000), 32'd1);
    repeat (exp_legal ? 3 : 10) step();
    check("err_pulses", err_cnt, exp_err);
    check("word_count", out_cnt, exp_words);
    check("busy_after", 32'(busy), 32'd0);
    if (exp_legal)
      check("signal_latency", first_valid_cyc - hs_cfg_cyc, exp_nsym + 2);
  endtask

  task automatic check_reset(input string tag);
    check(tag, {26'd0, cfg_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, err}, 32'd0);
    check(tag, {4'd0, m_axis_tuser, m_axis_tdata}, 32'd0);
  endtask

  initial begin
    logic [3:0] rates [8];
    int budget;
    rates = '{R6, R9, R12, R18, R24, R36, R48, R54};
    areset = 1'b1; cfg_valid = 1'b0; cfg_rate = '0; cfg_length = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    cyc = 0; cfg_pending = 1'b0; s_acc = 1'b0; pay_idx = 0;
    stall_en = 1'b0; gaps_en = 1'b0; drop_tlast = 1'b0;
    repeat (3) step();
    check_reset("reset_values");
    areset = 1'b0;
    step();
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);

    run_frame(R6, 100, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("sig_6m_100", 32'(first_word), 32'h000C8B);
    check("words_6m_100", out_cnt, 36);
    run_frame(R36, 100, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("words_36m_100", out_cnt, 37);
    run_frame(R9, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("words_9m_1", out_cnt, 3);
    run_frame(R6, 100, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    run_frame(4'h0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_frame(R12, 50, 1'b0, 1'b1, 1'b0, 1'b0, 1);

    for (int f = 0; f < 14; f++)
      run_frame(rates[$urandom_range(0, 7)], $urandom_range(1, 200), 1'b0, 1'b0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    // Abandon a frame mid-payload
    prepare_frame(R6, 100, 1'b0, 1'b0, 1'b0, 1'b0);
    budget = 0;
    while (out_cnt < 8 && budget < 1000) begin
      step();
      budget++;
    end
    check("midframe_busy", 32'(busy), 32'd1);
    areset = 1'b1;
    exp_q.delete(); pay_q.delete(); pay_idx = 0;
    cfg_pending = 1'b0; cfg_valid = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_acc = 1'b0;
    step();
    check_reset("midframe_reset");
    areset = 1'b0;
    step();
    run_frame(R6, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("words_6m_1", out_cnt, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
